debouncer_multi: RTL and testbench
==================================

// Module: debouncer_multi
// PURPOSE
//  Parametrised N-channel switch/button debouncer, successor to the single-channel debouncer.
//  Each channel: N-flop synchroniser -> stability counter -> registered clean level.
//  Also produces one-cycle rise/fall event pulses and a long-press pulse.
//  Sits between raw board pins and control logic; 'tick' allows a shared prescaler.
// PARAMETERS
//  N_CH        4     number of independent input channels
//  CNT_W       16    width of per-channel stability and hold counters
//  STABLE_CYC  1000  consecutive enabled ticks of a new level before clean_out follows (>=2, <2^CNT_W)
//  LONG_CYC    50000 enabled ticks of clean_out==1 before long_pulse fires (0 = long-press disabled, <2^CNT_W)
//  SYNC_STG    2     synchroniser flop stages (>=2)
//  INIT_LVL    1'b0  reset value of synchroniser and clean_out, applied to all channels
// PORTS
//  clk         in   1     system clock, all logic on rising edge
//  rst         in   1     synchronous, active-high reset
//  noisy_in    in   N_CH  raw asynchronous inputs, one bit per channel
//  tick        in   1     count enable; tie 1 to count every clk
//  clean_out   out  N_CH  debounced level per channel
//  rise_pulse  out  N_CH  1-clk pulse when clean_out goes 0->1
//  fall_pulse  out  N_CH  1-clk pulse when clean_out goes 1->0
//  long_pulse  out  N_CH  1-clk pulse once per press when high held LONG_CYC ticks
//  any_event   out  1     OR of all rise/fall/long pulses
// BEHAVIOUR
//  Reset (rst=1 at edge): sync flops, clean_out = INIT_LVL; counters = 0; all pulses and any_event = 0.
//  Channels fully independent; any number of channels may pulse in the same cycle.
//  Synchroniser runs every clk regardless of tick; s = last synchroniser stage.
//  Stability counter per edge (rst=0):
//   - s == clean_out: cnt <= 0 (any bounce restarts the count; applies even when tick=0).
//   - s != clean_out, tick=1, cnt == STABLE_CYC-1: clean_out <= s, cnt <= 0, rise/fall pulse <= 1.
//   - s != clean_out, tick=1, otherwise: cnt <= cnt+1.
//   - s != clean_out, tick=0: cnt holds.
//  Latency (tick=1): clean_out updates SYNC_STG+STABLE_CYC edges after noisy_in changes.
//   Count the first edge that samples the new value as edge 1.
//   Glitches shorter than STABLE_CYC ticks never reach clean_out.
//  Pulses are registered, asserted in the same cycle clean_out shows its new value, and low the next cycle.
//  Long-press (LONG_CYC>0), hold counter per channel:
//   - clean_out==0: hcnt <= 0, long-press armed.
//   - clean_out==1, tick=1, armed: hcnt++; on hcnt==LONG_CYC-1: long_pulse=1, disarm.
//   - disarmed: no further long_pulse until clean_out falls (re-arm). hcnt stays within CNT_W.
//  LONG_CYC=0: long_pulse tied 0; hold logic may be optimised away.
//  any_event is registered; it asserts in the same cycle as the pulses it ORs.
//  Reset mid-count: counts discarded, no pulse on reset cycle.
//   If the input differs from INIT_LVL after release, it debounces normally and then pulses.
// TESTING  (N_CH=4, SYNC_STG=2, STABLE_CYC=4, LONG_CYC=8, INIT_LVL=0, CNT_W=8)
//  1 Reset held with ch0=1 -> clean_out=0000, no pulses.
//    After release, ch0 clean=1 at edge 6 with rise_pulse[0] and any_event for one clk.
//  2 ch1 toggles 1,0,1,0 every clk, then holds 1 -> no change during bounce.
//    clean_out[1] rises 6 edges after the final 0->1.
//  3 tick=1 every 3rd clk, ch2 steps to 1 -> clean_out[2] rises only after 4 tick-qualified mismatch cycles.
//  4 ch0 clean high held 20 ticks -> exactly one long_pulse[0], 8 ticks after rise.
//    Release then re-press -> a second long_pulse.
//  5 ch0 and ch3 change on the same edge -> rise_pulse=1001 in one cycle; any_event single pulse.
//  6 rst asserted mid-count on ch1 (cnt=2) -> no pulse; after release, full 6-edge latency from scratch.

Source files
------------

// File: rtl/debouncer_multi.sv
// N-channel debouncer: synchroniser, stability counter and registered clean level per channel,
// plus registered rise/fall/long-press pulses and a combined any_event flag.
module debouncer_multi #(
  parameter int       N_CH       = 4,
  parameter int       CNT_W      = 16,
  parameter int       STABLE_CYC = 1000,
  parameter int       LONG_CYC   = 50000,
  parameter int       SYNC_STG   = 2,
  parameter bit       INIT_LVL   = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] noisy_in,
  input  logic            tick,
  output logic [N_CH-1:0] clean_out,
  output logic [N_CH-1:0] rise_pulse,
  output logic [N_CH-1:0] fall_pulse,
  output logic [N_CH-1:0] long_pulse,
  output logic            any_event
);

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYC - 1);

  logic [N_CH-1:0] sync_q [SYNC_STG];
  logic [N_CH-1:0] sync_s;
  logic [N_CH-1:0] rise_d, fall_d, long_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STG; i++) sync_q[i] <= {N_CH{INIT_LVL}};
    end else begin
      sync_q[0] <= noisy_in;
      for (int i = 1; i < SYNC_STG; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync_s = sync_q[SYNC_STG-1];

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic             clean_q;
    logic             fire;

    // A level change is accepted only on the tick that completes the stable run.
    assign fire      = (sync_s[c] != clean_q) && tick && (cnt == STABLE_LAST);
    assign rise_d[c] = fire && sync_s[c];
    assign fall_d[c] = fire && !sync_s[c];
    assign clean_out[c] = clean_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt     <= '0;
        clean_q <= INIT_LVL;
      end else if (sync_s[c] == clean_q) begin
        cnt <= '0;
      end else if (fire) begin
        cnt     <= '0;
        clean_q <= sync_s[c];
      end else if (tick) begin
        cnt <= cnt + 1'b1;
      end
    end

    if (LONG_CYC > 0) begin : g_long
      localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
      logic [CNT_W-1:0] hcnt;
      logic             armed;

      assign long_d[c] = clean_q && tick && armed && (hcnt == LONG_LAST);

      // Disarmed channels hold hcnt until clean_out drops, so it never wraps.
      always_ff @(posedge clk) begin
        if (rst) begin
          hcnt  <= '0;
          armed <= 1'b1;
        end else if (!clean_q) begin
          hcnt  <= '0;
          armed <= 1'b1;
        end else if (tick && armed) begin
          if (hcnt == LONG_LAST) armed <= 1'b0;
          else                   hcnt  <= hcnt + 1'b1;
        end
      end
    end else begin : g_nolong
      assign long_d[c] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rise_pulse <= '0;
      fall_pulse <= '0;
      long_pulse <= '0;
      any_event  <= 1'b0;
    end else begin
      rise_pulse <= rise_d;
      fall_pulse <= fall_d;
      long_pulse <= long_d;
      any_event  <= |{rise_d, fall_d, long_d};
    end
  end

endmodule

// File: tb/tb_debouncer_multi.sv
// Directed bench for debouncer_multi: reset/latency vector table plus hand-written multi-cycle sequences.
module tb_debouncer_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] noisy_in;
  logic       tick;
  logic [3:0] clean_out, rise_pulse, fall_pulse, long_pulse;
  logic       any_event;

  int checks = 0;
  int errors = 0;

  // Per-window observation results, filled by watch()
  int rise_e, fall_e, long_e, rise_n, fall_n, long_n, any_n, any_bad;
  logic [3:0] rise_v, fall_v, long_v;

  typedef struct {
    logic       rst;
    logic [3:0] noisy;
    logic       tick;
    logic [16:0] exp; // {clean, rise, fall, long, any}
  } vec_t;

  vec_t tbl [9];

  debouncer_multi #(
    .N_CH(4), .CNT_W(8), .STABLE_CYC(4), .LONG_CYC(8), .SYNC_STG(2), .INIT_LVL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .noisy_in(noisy_in), .tick(tick),
    .clean_out(clean_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .long_pulse(long_pulse), .any_event(any_event)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Steps n edges; tick is high on edges whose 1-based index is a multiple of tper.
  task automatic watch(input int n, input int tper);
    rise_e = 0; fall_e = 0; long_e = 0;
    rise_n = 0; fall_n = 0; long_n = 0; any_n = 0; any_bad = 0;
    rise_v = '0; fall_v = '0; long_v = '0;
    for (int e = 1; e <= n; e++) begin
      tick = (e % tper == 0);
      @(posedge clk);
      @(negedge clk);
      if (rise_pulse != 0) begin rise_n++; if (rise_e == 0) begin rise_e = e; rise_v = rise_pulse; end end
      if (fall_pulse != 0) begin fall_n++; if (fall_e == 0) begin fall_e = e; fall_v = fall_pulse; end end
      if (long_pulse != 0) begin long_n++; if (long_e == 0) begin long_e = e; long_v = long_pulse; end end
      if (any_event) any_n++;
      if (any_event !== |{rise_pulse, fall_pulse, long_pulse}) any_bad++;
    end
    tick = 1'b1;
  endtask

  initial begin
    int bad;
    rst = 1'b1; noisy_in = 4'b0000; tick = 1'b1;

    // Test 1: reset held with ch0 high, then release; rise lands on edge 6
    tbl[0] = '{1'b1, 4'b0001, 1'b1, {4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0}};
    tbl[1] = '{1'b1, 4'b0001, 1'b1, {4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0}};
    for (int i = 2; i <= 6; i++)
      tbl[i] = '{1'b0, 4'b0001, 1'b1, {4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0}};
    tbl[7] = '{1'b0, 4'b0001, 1'b1, {4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b1}};
    tbl[8] = '{1'b0, 4'b0001, 1'b1, {4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0}};

    for (int i = 0; i < 9; i++) begin
      rst = tbl[i].rst; noisy_in = tbl[i].noisy; tick = tbl[i].tick;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("t1_row%0d", i),
          32'({clean_out, rise_pulse, fall_pulse, long_pulse, any_event}), 32'(tbl[i].exp));
    end

    // Test 4: ch0 rose at edge 6 (table ended on edge 7); long pulse due at edge 14
    watch(19, 1);
    chk("t4_long_n", long_n, 1);
    chk("t4_long_e", long_e, 7);
    chk("t4_long_v", 32'(long_v), 32'h1);
    chk("t4_any_n", any_n, 1);
    noisy_in = 4'b0000;
    watch(8, 1);
    chk("t4_fall_e", fall_e, 6);
    chk("t4_fall_v", 32'(fall_v), 32'h1);
    noisy_in = 4'b0001;
    watch(16, 1);
    chk("t4_rise_e2", rise_e, 6);
    chk("t4_long_e2", long_e, 14);
    chk("t4_long_n2", long_n, 1);
    noisy_in = 4'b0000;
    watch(8, 1);
    chk("t4_rel_fall_e", fall_e, 6);
    chk("t4_rel_no_long", long_n, 0);

    // Test 2: ch1 bounces every clk, then settles high
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      noisy_in = (i % 2 == 0) ? 4'b0010 : 4'b0000;
      @(posedge clk);
      @(negedge clk);
      if (clean_out != 0 || rise_pulse != 0 || fall_pulse != 0) bad++;
    end
    noisy_in = 4'b0010;
    watch(16, 1);
    chk("t2_bounce", bad, 0);
    chk("t2_rise_e", rise_e, 6);
    chk("t2_rise_v", 32'(rise_v), 32'h2);
    chk("t2_rise_n", rise_n, 1);
    chk("t2_long_e", long_e, 14);
    noisy_in = 4'b0000;
    watch(8, 1);
    chk("t2_fall_e", fall_e, 6);
    chk("t2_fall_v", 32'(fall_v), 32'h2);

    // Test 3: tick every 3rd clk; mismatch ticks at edges 3,6,9,12
    noisy_in = 4'b0100;
    watch(14, 3);
    chk("t3_rise_e", rise_e, 12);
    chk("t3_rise_v", 32'(rise_v), 32'h4);
    noisy_in = 4'b0000;
    watch(8, 1);
    chk("t3_fall_e", fall_e, 6);

    // Test 5: ch0 and ch3 together
    noisy_in = 4'b1001;
    watch(10, 1);
    chk("t5_rise_e", rise_e, 6);
    chk("t5_rise_v", 32'(rise_v), 32'h9);
    chk("t5_rise_n", rise_n, 1);
    chk("t5_any_n", any_n, 1);
    noisy_in = 4'b0000;
    watch(8, 1);
    chk("t5_long_e", long_e, 4);
    chk("t5_long_v", 32'(long_v), 32'h9);
    chk("t5_fall_e", fall_e, 6);
    chk("t5_fall_v", 32'(fall_v), 32'h9);
    chk("t5_any_n2", any_n, 2);

    // Test 6: reset with ch1 count at 2, then full latency from scratch
    noisy_in = 4'b0010;
    watch(4, 1);
    chk("t6_pre_rise_n", rise_n, 0);
    rst = 1'b1;
    watch(1, 1);
    chk("t6_rst_out", 32'({clean_out, rise_pulse, fall_pulse, long_pulse, any_event}), 32'h0);
    rst = 1'b0;
    watch(10, 1);
    chk("t6_rise_e", rise_e, 6);
    chk("t6_rise_v", 32'(rise_v), 32'h2);
    chk("t6_any_consistent", any_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
